// File: rtl/bexkat1_pkg.sv
// Shared bexkat1 types and constants.
// Used by the instruction prefetch unit.
package bexkat1_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ir_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle.
// Master drives the request, slave answers with ack/stall.
interface if_wb;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, stall
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Instruction word FIFO: {data, pc} entries,
// synchronous clear, head visible while non-empty.
module prefetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [63:0]              wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [63:0]              head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // Credit accounting upstream must keep this from firing.
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push && count == FULL)
  );

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: pipelined Wishbone reads into a
// small FIFO, with credit flow control and redirect flush.
module ifetch_prefetch
  import bexkat1_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_wb.master        bus,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  state_t        state;
  logic [31:0]   fetch_adr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [CW-1:0] nxt_out;
  logic [CW-1:0] nxt_count;
  logic          credit;
  logic          nxt_credit;
  logic          accept;
  logic          ack_in;
  logic          push;
  logic          pop;
  ir_entry_t     head;
  ir_entry_t     wr_entry;

  assign bus.cyc   = (state != S_IDLE);
  assign bus.stb   = (state == S_FETCH) && credit && !pc_load;
  assign bus.we    = 1'b0;
  assign bus.sel   = 4'hf;
  assign bus.dat_m = '0;
  assign bus.adr   = word_align(fetch_adr);

  assign credit = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;
  assign accept = bus.cyc && bus.stb && !bus.stall;
  assign ack_in = bus.ack && bus.cyc && (outstanding != '0);
  assign push   = ack_in && (state == S_FETCH) && !pc_load;
  assign pop    = ir_valid && ir_ready && !pc_load;

  assign nxt_out   = outstanding + CW'(accept) - CW'(ack_in);
  assign nxt_count = pc_load ? '0
                   : count + CW'(push) - CW'(pop);
  assign nxt_credit =
    ({1'b0, nxt_count} + {1'b0, nxt_out}) < DEPTH_W;

  // Requests are issued back to back, so the oldest one
  // sits `outstanding` words behind the fetch address.
  assign wr_entry.data = bus.dat_s;
  assign wr_entry.pc   = fetch_adr - (32'(outstanding) << 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      fetch_adr   <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= nxt_out;
      if (accept)
        fetch_adr <= fetch_adr + 32'(WORD_BYTES);
      if (pc_load) begin
        fetch_adr <= word_align(pc_new);
        state <= (nxt_out != '0) ? S_FLUSH : S_FETCH;
      end else begin
        unique case (state)
          S_IDLE:  if (credit) state <= S_FETCH;
          S_FETCH: if (!nxt_credit && nxt_out == '0)
                     state <= S_IDLE;
          S_FLUSH: if (nxt_out == '0) state <= S_FETCH;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (pc_load),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .count (count),
    .head  (head)
  );

  assign ir_valid = (count != '0);
  assign ir_data  = head.data;
  assign ir_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: Wishbone RAM responder with
// latency/stall, and a stream-level reference model.
module tb_ifetch_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        ir_ready;

  if_wb bus ();

  ifetch_prefetch #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus      (bus),
    .pc_load  (pc_load),
    .pc_new   (pc_new),
    .ir_valid (ir_valid),
    .ir_data  (ir_data),
    .ir_pc    (ir_pc),
    .ir_ready (ir_ready)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(
    input logic [31:0] a
  );
    if (a < 32'h10)
      return 32'h11111111 * ((a >> 2) + 32'd1);
    return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // RAM responder: fixed latency, random stall.
  int          ram_delay = 1;
  int          stall_pct = 0;
  int          cyc_no = 0;
  logic [31:0] pend_adr[$];
  int          pend_due[$];

  initial begin
    bus.ack   = 1'b0;
    bus.dat_s = '0;
    bus.stall = 1'b0;
  end

  always @(posedge clk_i) begin
    cyc_no <= cyc_no + 1;
    bus.stall <= ($urandom_range(99) < stall_pct);
    if (!bus.cyc) begin
      pend_adr.delete();
      pend_due.delete();
      bus.ack <= 1'b0;
    end else begin
      if (bus.stb && !bus.stall) begin
        pend_adr.push_back(bus.adr);
        pend_due.push_back(cyc_no + ram_delay - 1);
      end
      if (pend_adr.size() > 0 && pend_due[0] <= cyc_no) begin
        bus.ack   <= 1'b1;
        bus.dat_s <= ram_word(pend_adr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.ack <= 1'b0;
      end
    end
  end

  // Reference model: consumer sees target, target+4, ...
  logic [31:0] exp_pc, exp_issue, first_adr;
  logic [31:0] prev_data, prev_pc;
  int          issued, popped, acc_total;
  bit          hold_prev, empty_next;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_pc     = RESET_PC;
      exp_issue  = RESET_PC;
      issued     = 0;
      popped     = 0;
      acc_total  = 0;
      hold_prev  = 0;
      empty_next = 0;
    end else begin
      chk("bus_we_sel", {27'b0, bus.we, bus.sel}, 32'hf);
      chk("bus_dat_m", bus.dat_m, 32'h0);
      if (bus.stb) chk("stb_needs_cyc", 32'(bus.cyc), 1);
      if (empty_next) chk("flush_empty", 32'(ir_valid), 0);
      if (hold_prev) begin
        chk("hold_data", ir_data, prev_data);
        chk("hold_pc", ir_pc, prev_pc);
      end
      if (bus.cyc && bus.stb && !bus.stall) begin
        if (issued == 0) first_adr = bus.adr;
        chk("issue_adr", bus.adr, exp_issue);
        exp_issue = exp_issue + 32'd4;
        issued++;
        acc_total++;
      end
      if (ir_valid && ir_ready && !pc_load) begin
        chk("pop_pc", ir_pc, exp_pc);
        chk("pop_data", ir_data, ram_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      chk("credit", 32'(issued - popped <= DEPTH), 1);
      hold_prev  = ir_valid && !ir_ready && !pc_load;
      prev_data  = ir_data;
      prev_pc    = ir_pc;
      empty_next = pc_load;
      if (pc_load) begin
        exp_pc    = pc_new & ~32'h3;
        exp_issue = pc_new & ~32'h3;
        issued    = 0;
        popped    = 0;
      end
    end
  end

  task automatic hold_reset();
    rst_i   = 1'b1;
    pc_load = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ir_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    int  lat;
    bit  found;
    rst_i    = 1'b1;
    pc_load  = 1'b0;
    pc_new   = '0;
    ir_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cyc", 32'(bus.cyc), 0);
    chk("rst_stb", 32'(bus.stb), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_data", ir_data, 0);
    chk("rst_pc", ir_pc, 0);

    // Streaming start-up
    ir_ready = 1'b1;
    rst_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_i);
      #1;
      if (ir_valid) begin
        lat = i;
        break;
      end
    end
    chk("first_lat_ok", 32'(lat >= 2 && lat <= 3), 1);
    chk("first_pc", ir_pc, 32'h0);
    chk("first_data", ir_data, 32'h11111111);
    repeat (12) @(posedge clk_i);
    #1;

    // Consumer stalled: exactly DEPTH requests, then idle
    hold_reset();
    ir_ready = 1'b0;
    rst_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    chk("full_accepts", 32'(acc_total), DEPTH);
    chk("full_cyc", 32'(bus.cyc), 0);
    chk("full_data", ir_data, 32'h11111111);
    chk("full_pc", ir_pc, 32'h0);
    ir_ready = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;

    // Redirect with two requests in flight
    hold_reset();
    ram_delay = 3;
    ir_ready = 1'b0;
    rst_i = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (pend_adr.size() == 2) begin
        found = 1;
        break;
      end
    end
    chk("two_inflight", 32'(found), 1);
    pc_load = 1'b1;
    pc_new = 32'h103;
    @(posedge clk_i);
    #1;
    pc_load = 1'b0;
    wait_valid("redir_valid");
    chk("redir_pc", ir_pc, 32'h100);
    chk("redir_data", ir_data, ram_word(32'h100));
    chk("redir_adr", first_adr, 32'h100);
    ir_ready = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;

    // Redirect coinciding with ack and pop
    hold_reset();
    ram_delay = 1;
    ir_ready = 1'b1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk_i);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i);
      #1;
      if (bus.ack && ir_valid) begin
        found = 1;
        pc_load = 1'b1;
        pc_new = 32'h2000;
        break;
      end
    end
    chk("ack_pop_setup", 32'(found), 1);
    @(posedge clk_i);
    #1;
    pc_load = 1'b0;
    chk("ack_pop_empty", 32'(ir_valid), 0);
    repeat (30) @(posedge clk_i);
    #1;

    // Random traffic, two latencies
    for (int ph = 0; ph < 2; ph++) begin
      hold_reset();
      ram_delay = (ph == 0) ? 1 : 3;
      stall_pct = 30;
      rst_i = 1'b0;
      for (int c = 0; c < 5000; c++) begin
        @(posedge clk_i);
        #1;
        ir_ready = 1'($urandom_range(1));
        pc_load = ($urandom_range(99) < 2);
        if ($urandom_range(3) == 0)
          pc_new = 32'hFFFFFFF0 | 32'($urandom_range(15));
        else
          pc_new = $urandom;
      end
      pc_load = 1'b0;
      stall_pct = 0;
    end

    // Asynchronous reset mid-burst
    hold_reset();
    ram_delay = 1;
    ir_ready = 1'b1;
    rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3;
    chk("burst_active", 32'(bus.cyc && ir_valid), 1);
    rst_i = 1'b1;
    #1;
    chk("async_cyc", 32'(bus.cyc), 0);
    chk("async_valid", 32'(ir_valid), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    wait_valid("restart_valid");
    chk("restart_pc", ir_pc, RESET_PC);
    chk("restart_data", ir_data, ram_word(RESET_PC));
    repeat (20) @(posedge clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
